aes_key_expand: RTL and testbench



---
 rtl/aes_pkg.sv | 22 ++
 rtl/aes_sbox.sv | 46 ++++
 rtl/aes_key_expand.sv | 119 +++++++++++
 tb/tb_aes_key_expand.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-expansion slice.
//   AES_NR      number of rounds for AES-128
//   AES_KEY_W   cipher/round key width
//   aes_state_e key-expansion controller states
//   xtime()     multiply-by-x in GF(2^8) with the AES polynomial
package aes_pkg;

  localparam int unsigned AES_NR    = 10;
  localparam int unsigned AES_KEY_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } aes_state_e;

  // Reduction by x^8 + x^4 + x^3 + x + 1 when the top bit shifts out.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational.
//   din   8-bit input byte
//   dout  8-bit substituted byte
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign dout = SBOX[din];

endmodule

// File: rtl/aes_key_expand.sv
// Sequential AES-128 key expansion: one round key per clock, stored in a
// resettable flop array and served through a 1-cycle registered read port.
//   clk, rst_n   clock, synchronous active-low reset
//   key_in       cipher key, byte 0 in [127:120], sampled on accept
//   key_valid    key offer; accepted when key_valid && key_ready
//   key_ready    high in IDLE and DONE
//   busy         high in EXPAND
//   keys_ready   all NR+1 round keys valid
//   rk_idx       round-key read index (0..NR, larger reads zero)
//   rk_out       round key for the previous cycle's rk_idx
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AES_KEY_W-1:0] key_in,
  input  logic                 key_valid,
  output logic                 key_ready,
  output logic                 busy,
  output logic                 keys_ready,
  input  logic [3:0]           rk_idx,
  output logic [AES_KEY_W-1:0] rk_out
);

  aes_state_e           state_q;
  logic [AES_KEY_W-1:0] rk_q [NR+1];
  logic [3:0]           cnt_q;
  logic [7:0]           rcon_q;
  logic                 keys_ready_q;
  logic [AES_KEY_W-1:0] rk_out_q;

  logic [AES_KEY_W-1:0] prev_key;
  logic [AES_KEY_W-1:0] next_key;
  logic [AES_KEY_W-1:0] rd_data;
  logic [31:0]          w0, w1, w2, w3;
  logic [31:0]          rot_w3, sub_w3, t;

  assign key_ready  = (state_q == IDLE) || (state_q == DONE);
  assign busy       = (state_q == EXPAND);
  assign keys_ready = keys_ready_q;
  assign rk_out     = rk_out_q;

  // Select rk[cnt-1] as the source of the current step; zero outside EXPAND.
  always_comb begin
    prev_key = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (cnt_q == 4'(i + 1)) prev_key = rk_q[i];
    end
  end

  assign w0     = prev_key[127:96];
  assign w1     = prev_key[95:64];
  assign w2     = prev_key[63:32];
  assign w3     = prev_key[31:0];
  assign rot_w3 = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .din  (rot_w3[8*b +: 8]),
      .dout (sub_w3[8*b +: 8])
    );
  end

  assign t = sub_w3 ^ {rcon_q, 24'h0};

  // Each output word is the running XOR of the input words with t folded in.
  always_comb begin
    next_key[127:96] = w0 ^ t;
    next_key[95:64]  = w1 ^ w0 ^ t;
    next_key[63:32]  = w2 ^ w1 ^ w0 ^ t;
    next_key[31:0]   = w3 ^ w2 ^ w1 ^ w0 ^ t;
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i <= NR; i++) begin
      if (rk_idx == 4'(i)) rd_data = rk_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      rcon_q       <= 8'h01;
      keys_ready_q <= 1'b0;
      rk_out_q     <= '0;
      for (int unsigned i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else begin
      rk_out_q <= rd_data;
      case (state_q)
        IDLE, DONE: begin
          if (key_valid) begin
            state_q      <= EXPAND;
            rk_q[0]      <= key_in;
            cnt_q        <= 4'd1;
            rcon_q       <= 8'h01;
            keys_ready_q <= 1'b0;
          end
        end
        EXPAND: begin
          for (int unsigned i = 1; i <= NR; i++) begin
            if (cnt_q == 4'(i)) rk_q[i] <= next_key;
          end
          rcon_q <= xtime(rcon_q);
          cnt_q  <= cnt_q + 4'd1;
          if (cnt_q == 4'(NR)) begin
            state_q      <= DONE;
            keys_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         keys_ready;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [11];

  aes_key_expand #(.NR(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_ready (keys_ready),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from the field inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
    end
  endtask

  // Word-oriented schedule w[0..43].
  task automatic model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input int idx, input logic [127:0] exp, input string tag);
    rk_idx = 4'(idx);
    tick();
    chk(tag, rk_out, exp);
  endtask

  // Accept a key and wait (bounded) for keys_ready.
  task automatic run_expand(input logic [127:0] key, input string tag);
    int waited = 0;
    key_in    = key;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    while (!keys_ready && waited < 20) begin
      tick();
      waited++;
    end
    chk({tag, "_done"}, 128'(keys_ready), 128'(1));
  endtask

  task automatic check_all(input string tag);
    for (int i = 10; i >= 0; i--) read_chk(i, exp_rk[i], $sformatf("%s_rk%0d", tag, i));
  endtask

  initial begin
    logic [127:0] key_a, key_b, key_c;
    build_sbox();
    rst_n = 1'b0; key_valid = 1'b0; key_in = '0; rk_idx = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();

    // Reset state
    chk("rst_key_ready", 128'(key_ready), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_keys_ready", 128'(keys_ready), 128'(0));
    for (int i = 0; i < 16; i++) read_chk(i, 128'h0, $sformatf("rst_rk%0d", i));

    // FIPS-197 key with cycle-exact keys_ready
    key_a = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model(key_a);
    key_in = key_a; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk("fips_busy_T", 128'(busy), 128'(1));
    chk("fips_key_ready_T", 128'(key_ready), 128'(0));
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk($sformatf("fips_keys_ready_T%0d", c), 128'(keys_ready), 128'(c == 10));
      chk($sformatf("fips_busy_T%0d", c), 128'(busy), 128'(c < 10));
    end
    read_chk(1, 128'ha0fafe1788542cb123a339392a6c7605, "fips_rk1_const");
    read_chk(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_rk10_const");
    check_all("fips");

    // Sequential key, back-to-back reads 10..0 then out-of-range index
    key_b = 128'h000102030405060708090a0b0c0d0e0f;
    model(key_b);
    run_expand(key_b, "seq");
    read_chk(10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "seq_rk10_const");
    check_all("seq");
    read_chk(15, 128'h0, "seq_idx15");
    read_chk(11, 128'h0, "seq_idx11");

    // Random key with a key_valid pulse mid-expansion
    key_a = {$urandom, $urandom, $urandom, $urandom};
    key_c = {$urandom, $urandom, $urandom, $urandom};
    model(key_a);
    key_in = key_a; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    tick(); tick();
    key_in = key_c; key_valid = 1'b1;
    chk("mid_key_ready", 128'(key_ready), 128'(0));
    tick();
    key_valid = 1'b0;
    for (int w = 0; w < 20 && !keys_ready; w++) tick();
    chk("mid_done", 128'(keys_ready), 128'(1));
    check_all("mid");

    // Rekey from DONE
    key_b = {$urandom, $urandom, $urandom, $urandom};
    model(key_b);
    key_in = key_b; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk("rekey_drop", 128'(keys_ready), 128'(0));
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk($sformatf("rekey_keys_ready_T%0d", c), 128'(keys_ready), 128'(c == 10));
    end
    read_chk(10, exp_rk[10], "rekey_rk10");

    // Reset during expansion
    key_in = key_c; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_busy", 128'(busy), 128'(0));
    chk("mrst_key_ready", 128'(key_ready), 128'(1));
    chk("mrst_keys_ready", 128'(keys_ready), 128'(0));
    chk("mrst_rk_out", rk_out, 128'h0);
    for (int i = 0; i <= 10; i++) read_chk(i, 128'h0, $sformatf("mrst_rk%0d", i));
    model(key_c);
    run_expand(key_c, "fresh");
    check_all("fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
